// File: rtl/alu_pkg.sv
// Shared constants for the ALU rotate/shift sequencer: op encodings, sizes and FSM states.
package alu_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned NumStages = 5;

  localparam logic [2:0] OpRor = 3'd0;
  localparam logic [2:0] OpRol = 3'd1;
  localparam logic [2:0] OpShr = 3'd2;
  localparam logic [2:0] OpShl = 3'd3;
  localparam logic [2:0] OpSra = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One log-step of rotate/shift: moves acc by 2^cnt positions; illegal ops pass acc through.
module shift_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = DataWidth,
  parameter int unsigned STAGES = NumStages
) (
  input  logic [WIDTH-1:0]          acc,
  input  logic [2:0]                op,
  input  logic [$clog2(STAGES)-1:0] cnt,
  output logic [WIDTH-1:0]          stepped
);

  int unsigned k;

  always_comb begin
    k       = 32'd1 << cnt;
    stepped = acc;
    unique case (op)
      OpRor:   stepped = (acc >> k) | (acc << (WIDTH - k));
      OpRol:   stepped = (acc << k) | (acc >> (WIDTH - k));
      OpShr:   stepped = acc >> k;
      OpShl:   stepped = acc << k;
      OpSra:   stepped = $unsigned($signed(acc) >>> k);
      default: stepped = acc;
    endcase
  end

endmodule

// File: rtl/rotate_shift_seq.sv
// Multi-cycle rotate/shift sequencer: one log-step per cycle, fixed latency, start/busy/done.
module rotate_shift_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = DataWidth,
  parameter int unsigned STAGES = NumStages
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic             illegal
);

  localparam int unsigned CntW = $clog2(STAGES);

  state_e            state;
  logic [2:0]        op_q;
  logic [STAGES-1:0] amt;
  logic [CntW-1:0]   cnt;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  stepped;
  logic [WIDTH-1:0]  acc_next;

  // Only A mod WIDTH matters; upper amount bits are intentionally dropped.
  logic unused_a_hi;
  assign unused_a_hi = ^A[WIDTH-1:STAGES];

  shift_step #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) u_step (
    .acc    (acc),
    .op     (op_q),
    .cnt    (cnt),
    .stepped(stepped)
  );

  assign acc_next = amt[cnt] ? stepped : acc;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= StIdle;
      op_q    <= '0;
      amt     <= '0;
      cnt     <= '0;
      acc     <= '0;
      R       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          if (start) begin
            op_q  <= op;
            amt   <= A[STAGES-1:0];
            acc   <= B;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          acc <= acc_next;
          if (cnt == CntW'(STAGES - 1)) begin
            R       <= acc_next;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            illegal <= (op_q > OpSra);
            state   <= StDone;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_shift_seq.sv
// Directed self-checking bench for rotate_shift_seq with hand-computed results.
module tb_rotate_shift_seq;

  logic        clk;
  logic        clr;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] R;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  rotate_shift_seq dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .R      (R),
    .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issues one op, scrambles A/B after acceptance and observes the outcome.
  // lat counts edges from the accept edge (inclusive) to the edge that raises done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bc, output logic [31:0] r,
                        output logic ill, output logic done_next, output int stray_ill);
    bit seen;
    seen = 0; lat = 0; bc = 0; r = '0; ill = 1'b0; stray_ill = 0;
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      start = 1'b0;
      A = $urandom;
      B = $urandom;
      if (done) begin
        seen = 1; r = R; ill = illegal;
      end else begin
        if (busy) bc++;
        if (illegal) stray_ill++;
      end
    end
    @(posedge clk);
    #1;
    done_next = done;
    if (illegal) stray_ill++;
  endtask

  task automatic test_reset;
    clr = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (R !== 32'h0) begin n_fail++; $display("FAIL reset_R got %h want 0", R); end
    n_checks++;
    if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", illegal); end
    clr = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ror;
    int lat, bc, si; logic [31:0] r; logic ill, dn;
    run_op(3'd0, 32'd1, 32'h8000_0001, lat, bc, r, ill, dn, si);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL ror_latency got %0d want 6", lat); end
    n_checks++; if (bc !== 5) begin n_fail++; $display("FAIL ror_busy_cycles got %0d want 5", bc); end
    n_checks++; if (r !== 32'hC000_0000) begin n_fail++; $display("FAIL ror_R got %h want c0000000", r); end
    n_checks++; if (ill !== 1'b0) begin n_fail++; $display("FAIL ror_illegal got %b want 0", ill); end
    n_checks++; if (dn !== 1'b0) begin n_fail++; $display("FAIL ror_done_width got %b want 0", dn); end
    n_checks++; if (R !== 32'hC000_0000) begin n_fail++; $display("FAIL ror_R_hold got %h want c0000000", R); end
  endtask

  task automatic test_rol;
    int lat, bc, si; logic [31:0] r; logic ill, dn;
    run_op(3'd1, 32'd4, 32'h1234_5678, lat, bc, r, ill, dn, si);
    n_checks++; if (r !== 32'h2345_6781) begin n_fail++; $display("FAIL rol4_R got %h want 23456781", r); end
    run_op(3'd1, 32'd0, 32'hDEAD_BEEF, lat, bc, r, ill, dn, si);
    n_checks++; if (r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rol0_R got %h want deadbeef", r); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL rol0_latency got %0d want 6", lat); end
  endtask

  task automatic test_shifts;
    int lat, bc, si; logic [31:0] r; logic ill, dn;
    run_op(3'd4, 32'd33, 32'h8000_0000, lat, bc, r, ill, dn, si);
    n_checks++; if (r !== 32'hC000_0000) begin n_fail++; $display("FAIL sra33_R got %h want c0000000", r); end
    run_op(3'd2, 32'd31, 32'hFFFF_FFFF, lat, bc, r, ill, dn, si);
    n_checks++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL shr31_R got %h want 00000001", r); end
    run_op(3'd3, 32'd8, 32'h0000_00FF, lat, bc, r, ill, dn, si);
    n_checks++; if (r !== 32'h0000_FF00) begin n_fail++; $display("FAIL shl8_R got %h want 0000ff00", r); end
    run_op(3'd4, 32'd4, 32'h4000_0000, lat, bc, r, ill, dn, si);
    n_checks++; if (r !== 32'h0400_0000) begin n_fail++; $display("FAIL sra4_pos_R got %h want 04000000", r); end
  endtask

  task automatic test_illegal;
    int lat, bc, si; logic [31:0] r; logic ill, dn;
    run_op(3'd6, 32'd7, 32'h0BAD_F00D, lat, bc, r, ill, dn, si);
    n_checks++; if (r !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL illegal_R got %h want 0badf00d", r); end
    n_checks++; if (ill !== 1'b1) begin n_fail++; $display("FAIL illegal_flag got %b want 1", ill); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL illegal_latency got %0d want 6", lat); end
    n_checks++; if (si !== 0) begin n_fail++; $display("FAIL illegal_stray got %0d want 0", si); end
  endtask

  task automatic test_back_to_back;
    int t1, t2;
    @(negedge clk);
    op = 3'd0; A = 32'd16; B = 32'h0000_FFFF; start = 1'b1;
    @(posedge clk); #1;
    A = 32'd8; B = 32'h0000_00FF;
    t1 = 1;
    while (!done && t1 < 20) begin @(posedge clk); #1; t1++; end
    n_checks++; if (t1 !== 6) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 6", t1); end
    n_checks++; if (R !== 32'hFFFF_0000) begin n_fail++; $display("FAIL b2b_first_R got %h want ffff0000", R); end
    t2 = 0;
    do begin @(posedge clk); #1; t2++; end while (!done && t2 < 20);
    start = 1'b0;
    n_checks++; if (t2 !== 6) begin n_fail++; $display("FAIL b2b_second_period got %0d want 6", t2); end
    n_checks++; if (R !== 32'hFF00_0000) begin n_fail++; $display("FAIL b2b_second_R got %h want ff000000", R); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_ignored_start;
    int t, extra;
    @(negedge clk);
    op = 3'd3; A = 32'd8; B = 32'h0000_00FF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    op = 3'd0; A = 32'd1; B = 32'h1111_1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 3;
    while (!done && t < 20) begin @(posedge clk); #1; t++; end
    n_checks++; if (t !== 6) begin n_fail++; $display("FAIL ignored_latency got %0d want 6", t); end
    n_checks++; if (R !== 32'h0000_FF00) begin n_fail++; $display("FAIL ignored_R got %h want 0000ff00", R); end
    extra = 0;
    repeat (8) begin @(posedge clk); #1; if (busy || done) extra++; end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignored_queued got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid;
    int lat, bc, si, dn_cnt; logic [31:0] r; logic ill, dn;
    @(negedge clk);
    op = 3'd0; A = 32'd1; B = 32'h8000_0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
    n_checks++; if (R !== 32'h0) begin n_fail++; $display("FAIL midrst_R got %h want 0", R); end
    @(negedge clk);
    clr = 1'b1;
    dn_cnt = 0;
    repeat (8) begin @(posedge clk); #1; if (done) dn_cnt++; end
    n_checks++; if (dn_cnt !== 0) begin n_fail++; $display("FAIL midrst_done_after got %0d want 0", dn_cnt); end
    run_op(3'd1, 32'd4, 32'h1234_5678, lat, bc, r, ill, dn, si);
    n_checks++; if (r !== 32'h2345_6781) begin n_fail++; $display("FAIL midrst_next_R got %h want 23456781", r); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL midrst_next_latency got %0d want 6", lat); end
  endtask

  initial begin
    test_reset();
    test_ror();
    test_rol();
    test_shifts();
    test_illegal();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
